// File: rtl/uart_pkg.sv
// Shared types and constants for the UART frame scheduler.
// Optional build macro: UART_FRAME_CHECKSUM_EN. When it is defined, each frame
// ends with an XOR checksum byte.
package uart_pkg;

  // Upper nibble of every header byte. The lower nibble carries the channel ID.
  localparam logic [3:0] HDR_TAG = 4'hA;

  typedef enum logic [1:0] {
    IDLE,
    HDR,
    PAY,
    CSUM
  } sched_state_t;

  // Number of payload bytes carried by one channel word.
  function automatic int byte_count(input int data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter. The search starts one past the last granted channel,
// or at channel 0 when nothing has been granted yet.
module rr_arbiter #(
  parameter  int NUM_CH = 4,
  localparam int IDX_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] req,
  input  logic              advance,
  output logic [IDX_W-1:0]  gnt_idx,
  output logic              gnt_vld
);

  logic [IDX_W-1:0] start;
  logic [IDX_W-1:0] cand;

  // Scan from the highest offset down so the lowest offset from start wins.
  always_comb begin
    gnt_idx = '0;
    gnt_vld = 1'b0;
    cand    = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      cand = IDX_W'((int'(start) + i) % NUM_CH);
      if (req[cand]) begin
        gnt_idx = cand;
        gnt_vld = 1'b1;
      end
    end
  end

  // The pointer moves only when a grant is actually taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      start <= '0;
    end else if (advance && gnt_vld) begin
      start <= (int'(gnt_idx) == NUM_CH - 1) ? '0 : gnt_idx + IDX_W'(1);
    end
  end

endmodule

// File: rtl/uart_frame_scheduler.sv
// UART frame scheduler: serialises NUM_CH status words into tagged frames
// (header byte {A, ch}, then payload MSB byte first) for a UART TX FIFO.
// A channel is sent when its word changed, when its refresh is pending, or
// always while send_all is high.
// Optional build macro: UART_FRAME_CHECKSUM_EN appends an XOR checksum byte
// to each frame.
module uart_frame_scheduler
  import uart_pkg::*;
#(
  parameter int NUM_CH         = 4,
  parameter int DATA_W         = 8,
  parameter int REFRESH_CYCLES = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH*DATA_W-1:0] ch_data,
  input  logic                     send_all,
  input  logic                     tx_full,
  output logic                     wr_uart,
  output logic [7:0]               w_data,
  output logic                     busy
);

  localparam int BYTES = byte_count(DATA_W);
  localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int BI_W  = (BYTES > 1) ? $clog2(BYTES) : 1;

  logic [NUM_CH-1:0][DATA_W-1:0] ch_vec;
  logic [NUM_CH-1:0][DATA_W-1:0] shadow;
  logic [NUM_CH-1:0]             pend;
  logic [NUM_CH-1:0]             due;

  sched_state_t          state;
  logic [IDX_W-1:0]      g;
  logic [BYTES-1:0][7:0] payload;
  logic [BI_W-1:0]       bidx;

  logic [IDX_W-1:0] gnt_idx;
  logic             gnt_vld;
  logic             grant;
  logic             refresh_wrap;
  logic             can_wr;
  logic [7:0]       hdr_byte;
  logic [7:0]       cur_byte;

  assign ch_vec = ch_data;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_due
    assign due[k] = send_all | pend[k] | (ch_vec[k] != shadow[k]);
  end

  rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (due),
    .advance (state == IDLE),
    .gnt_idx (gnt_idx),
    .gnt_vld (gnt_vld)
  );

  assign grant = (state == IDLE) && gnt_vld;

  // Writes are held off for one cycle after every strobe. This gives the
  // FIFO time to update tx_full before the next write is decided.
  assign can_wr   = !tx_full && !wr_uart;
  assign hdr_byte = {HDR_TAG, 4'(g)};
  assign cur_byte = payload[bidx];

  if (REFRESH_CYCLES > 0) begin : g_refresh
    localparam int RC_W = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
    logic [RC_W-1:0] ref_cnt;

    assign refresh_wrap = (ref_cnt == RC_W'(REFRESH_CYCLES - 1));

    // Free-running refresh timer that wraps at REFRESH_CYCLES-1.
    always_ff @(posedge clk) begin
      if (rst) ref_cnt <= '0;
      else if (refresh_wrap) ref_cnt <= '0;
      else ref_cnt <= ref_cnt + RC_W'(1);
    end
  end else begin : g_no_refresh
    assign refresh_wrap = 1'b0;
  end

  // Shadow copies and pending bits. A grant snapshots the channel and clears
  // its pending bit. A refresh wrap re-arms every other channel.
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow <= '0;
      pend   <= '1;
    end else begin
      if (grant) begin
        shadow[gnt_idx] <= ch_vec[gnt_idx];
        pend[gnt_idx]   <= 1'b0;
      end
      if (refresh_wrap) begin
        for (int k = 0; k < NUM_CH; k++) begin
          if (!(grant && gnt_idx == IDX_W'(k))) pend[k] <= 1'b1;
        end
      end
    end
  end

`ifdef UART_FRAME_CHECKSUM_EN
  logic [7:0] csum;
`endif

  // Frame sequencer: grant, then header, payload bytes and optional checksum.
  // All outputs are registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      g       <= '0;
      payload <= '0;
      bidx    <= '0;
      wr_uart <= 1'b0;
      w_data  <= '0;
      busy    <= 1'b0;
`ifdef UART_FRAME_CHECKSUM_EN
      csum    <= '0;
`endif
    end else begin
      wr_uart <= 1'b0;
      case (state)
        IDLE: begin
          if (gnt_vld) begin
            g       <= gnt_idx;
            payload <= ch_vec[gnt_idx];
            busy    <= 1'b1;
            state   <= HDR;
          end else begin
            busy <= 1'b0;
          end
        end
        HDR: begin
          if (can_wr) begin
            wr_uart <= 1'b1;
            w_data  <= hdr_byte;
`ifdef UART_FRAME_CHECKSUM_EN
            csum    <= hdr_byte;
`endif
            bidx    <= BI_W'(BYTES - 1);
            state   <= PAY;
          end
        end
        PAY: begin
          if (can_wr) begin
            wr_uart <= 1'b1;
            w_data  <= cur_byte;
`ifdef UART_FRAME_CHECKSUM_EN
            csum    <= csum ^ cur_byte;
`endif
            if (bidx == '0) begin
`ifdef UART_FRAME_CHECKSUM_EN
              state <= CSUM;
`else
              state <= IDLE;
`endif
            end else begin
              bidx <= bidx - BI_W'(1);
            end
          end
        end
`ifdef UART_FRAME_CHECKSUM_EN
        CSUM: begin
          if (can_wr) begin
            wr_uart <= 1'b1;
            w_data  <= csum;
            state   <= IDLE;
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_frame_scheduler.sv
// Directed bench for uart_frame_scheduler. Instance a is 4x8-bit with no
// refresh. Instance b is 4x16-bit with REFRESH_CYCLES=100.
module tb_uart_frame_scheduler;

  logic        clk = 1'b0;
  logic        rst_a, rst_b;
  logic [31:0] data_a;
  logic [63:0] data_b;
  logic        send_all_a, send_all_b, tx_full_a, tx_full_b;
  logic        wr_a, wr_b, busy_a, busy_b;
  logic [7:0]  wd_a, wd_b;

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;
  int rel;
  int sz;
  int stall_wr;

  logic [7:0] cap_a[$];
  logic [7:0] cap_b[$];
  int   viol_a = 0, viol_b = 0;
  logic prev_a = 1'b0, prev_b = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_frame_scheduler #(.NUM_CH(4), .DATA_W(8), .REFRESH_CYCLES(0)) u_dut_a (
    .clk(clk), .rst(rst_a), .ch_data(data_a), .send_all(send_all_a),
    .tx_full(tx_full_a), .wr_uart(wr_a), .w_data(wd_a), .busy(busy_a)
  );

  uart_frame_scheduler #(.NUM_CH(4), .DATA_W(16), .REFRESH_CYCLES(100)) u_dut_b (
    .clk(clk), .rst(rst_b), .ch_data(data_b), .send_all(send_all_b),
    .tx_full(tx_full_b), .wr_uart(wr_b), .w_data(wd_b), .busy(busy_b)
  );

  // Capture every written byte and count back-to-back strobes.
  always @(negedge clk) begin
    if (wr_a) cap_a.push_back(wd_a);
    if (wr_a && prev_a) viol_a++;
    prev_a = wr_a;
    if (wr_b) cap_b.push_back(wd_b);
    if (wr_b && prev_b) viol_b++;
    prev_b = wr_b;
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s act=%h exp=%h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] pop_q(input int which);
    if (which == 0) begin
      if (cap_a.size() == 0) return 32'hDEAD;
      return {24'h0, cap_a.pop_front()};
    end
    if (cap_b.size() == 0) return 32'hDEAD;
    return {24'h0, cap_b.pop_front()};
  endfunction

  // Pop one frame and compare it with header {A,ch}, then nb payload bytes
  // MSB first, then the checksum when that build option is on.
  task automatic chk_frame(input int which, input string tag, input int ch,
                           input logic [31:0] d, input int nb);
    logic [7:0] hdr, b, cs;
    hdr = {4'hA, 4'(ch)};
    chk({tag, "_hdr"}, pop_q(which), {24'h0, hdr});
    cs = hdr;
    for (int i = nb - 1; i >= 0; i--) begin
      b = d[i*8 +: 8];
      chk({tag, "_pay"}, pop_q(which), {24'h0, b});
      cs = cs ^ b;
    end
`ifdef UART_FRAME_CHECKSUM_EN
    chk({tag, "_csum"}, pop_q(which), {24'h0, cs});
`endif
  endtask

  // Bounded wait for a strobe carrying val (or any strobe if any_wr is set).
  task automatic wait_wr(input int which, input logic [7:0] val, input bit any_wr,
                         input int budget, input string tag);
    bit ok;
    bit w;
    logic [7:0] d;
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      w = (which == 0) ? wr_a : wr_b;
      d = (which == 0) ? wd_a : wd_b;
      if (w && (any_wr || d == val)) ok = 1'b1;
    end
    chk(tag, {31'h0, ok}, 32'h1);
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  initial begin
    rst_a = 1'b1; rst_b = 1'b1;
    send_all_a = 1'b0; send_all_b = 1'b0;
    tx_full_a = 1'b0; tx_full_b = 1'b0;
    data_a = 32'h4433_2211;
    data_b = 64'h4444_3333_BEEF_1111;
    repeat (3) @(negedge clk);

    // Reset state.
    chk("rst_wr_a",   {31'h0, wr_a},   32'h0);
    chk("rst_wd_a",   {24'h0, wd_a},   32'h0);
    chk("rst_busy_a", {31'h0, busy_a}, 32'h0);
    chk("rst_wr_b",   {31'h0, wr_b},   32'h0);
    chk("rst_busy_b", {31'h0, busy_b}, 32'h0);

    // Post-reset latency: the grant edge comes first, then the header strobe.
    rst_a = 1'b0;
    @(posedge clk); #1;
    chk("lat_nowr", {31'h0, wr_a},   32'h0);
    chk("lat_busy", {31'h0, busy_a}, 32'h1);
    @(posedge clk); #1;
    chk("lat_wr",   {31'h0, wr_a},   32'h1);
    chk("lat_hdr",  {24'h0, wd_a},   32'hA0);

    // Post-reset sweep of all four channels.
    repeat (40) @(negedge clk);
    chk_frame(0, "init0", 0, 32'h11, 1);
    chk_frame(0, "init1", 1, 32'h22, 1);
    chk_frame(0, "init2", 2, 32'h33, 1);
    chk_frame(0, "init3", 3, 32'h44, 1);
    chk("init_quiet", cap_a.size(), 0);
    chk("init_idle",  {31'h0, busy_a}, 32'h0);

    // A single change sends only that channel.
    data_a[23:16] = 8'h5C;
    repeat (20) @(negedge clk);
    chk_frame(0, "chg2", 2, 32'h5C, 1);
    chk("chg_quiet", cap_a.size(), 0);

    // Streaming mode. The rotation resumes after ch2, so the next frame is ch3.
    // Changing ch3 right after its header leaves the old payload in that frame.
    send_all_a = 1'b1;
    wait_wr(0, 8'hA3, 1'b0, 30, "strm_a3_seen");
    data_a[31:24] = 8'h99;
    @(posedge clk); #1;
    cap_a.delete();
    repeat (40) @(negedge clk);
    chk("strm_old3", pop_q(0), 32'h44);
`ifdef UART_FRAME_CHECKSUM_EN
    chk("strm_old3_cs", pop_q(0), 32'hE7);
`endif
    chk_frame(0, "strm0", 0, 32'h11, 1);
    chk_frame(0, "strm1", 1, 32'h22, 1);
    chk_frame(0, "strm2", 2, 32'h5C, 1);
    chk_frame(0, "strm3", 3, 32'h99, 1);
    send_all_a = 1'b0;
    repeat (30) @(negedge clk);
    @(posedge clk); #1;
    cap_a.delete();
    repeat (30) @(negedge clk);
    chk("strm_off_quiet", cap_a.size(), 0);

    // Instance b: a tx_full stall in the middle of the ch1 payload.
    chk("b_held_quiet", cap_b.size(), 0);
    rst_b = 1'b0;
    rel = cyc;
    wait_wr(1, 8'hA1, 1'b0, 40, "b_a1_seen");
    tx_full_b = 1'b1;
    stall_wr = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (wr_b) stall_wr++;
    end
    chk("stall_nowr", stall_wr, 0);
    tx_full_b = 1'b0;
    wait_until(rel + 60);
    chk_frame(1, "b_init0", 0, 32'h1111, 2);
    chk_frame(1, "b_init1", 1, 32'hBEEF, 2);
    chk_frame(1, "b_init2", 2, 32'h3333, 2);
    chk_frame(1, "b_init3", 3, 32'h4444, 2);
    chk("b_init_quiet", cap_b.size(), 0);

    // Refresh: static data is resent once in each 100-cycle window.
    wait_until(rel + 260);
    for (int r = 0; r < 2; r++) begin
      chk_frame(1, "ref0", 0, 32'h1111, 2);
      chk_frame(1, "ref1", 1, 32'hBEEF, 2);
      chk_frame(1, "ref2", 2, 32'h3333, 2);
      chk_frame(1, "ref3", 3, 32'h4444, 2);
    end
    chk("ref_quiet", cap_b.size(), 0);
    chk("ref_idle", {31'h0, busy_b}, 32'h0);

    // Reset while a payload strobe is high: the frame is dropped, then the
    // full post-reset sweep runs again.
    wait_wr(1, 8'hA2, 1'b0, 200, "b_a2_seen");
    wait_wr(1, 8'h00, 1'b1, 6, "b_pay_seen");
    rst_b = 1'b1;
    @(posedge clk); #1;
    chk("midrst_wr",   {31'h0, wr_b},   32'h0);
    chk("midrst_busy", {31'h0, busy_b}, 32'h0);
    @(negedge clk);
    cap_b.delete();
    rst_b = 1'b0;
    rel = cyc;
    wait_until(rel + 60);
    chk_frame(1, "rr0", 0, 32'h1111, 2);
    chk_frame(1, "rr1", 1, 32'hBEEF, 2);
    chk_frame(1, "rr2", 2, 32'h3333, 2);
    chk_frame(1, "rr3", 3, 32'h4444, 2);
    chk("rr_quiet", cap_b.size(), 0);

    chk("spacing_a", viol_a, 0);
    chk("spacing_b", viol_b, 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
